i2c_target_regs: RTL and testbench

I2C target (slave) endpoint: the responder side of the bus our i2c_master blocks drive. It lets an external controller (bench fixture, companion MCU) write and read a small bank of 8-bit control registers, such as the PA bias settings, over a two-wire port. The block filters SCL/SDA, detects START/STOP, matches a fixed 7-bit address, and runs a pointer-then-data register protocol. It presents a simple register write strobe and read port to the fabric.

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_line_filter.sv | 60 ++++++
 rtl/i2c_target_regs.sv | 262 ++++++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target register endpoint.
//   i2c_state_e  : protocol FSM states
//   RwBit        : position of the R/W flag in the address byte (1 = read)
//   AckLevel     : SDA level meaning ACK; NackLevel : SDA level meaning NACK
//   BitCntW      : width of the per-byte bit counter (counts 0..8)
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAckAddr,
    StWrPtr,
    StAckPtr,
    StWrData,
    StAckData,
    StRdData,
    StRdAck,
    StIgnore
  } i2c_state_e;

  localparam int unsigned RwBit     = 0;
  localparam logic        AckLevel  = 1'b0;
  localparam logic        NackLevel = 1'b1;

  localparam int unsigned         BitCntW     = 4;
  localparam logic [BitCntW-1:0] BitsPerByte = 4'd8;
  localparam logic [BitCntW-1:0] LastBit     = 4'd7;

endpackage

// File: rtl/i2c_line_filter.sv
// Input conditioner for one I2C line: 2-FF synchronizer followed by a
// consecutive-sample filter, plus edge pulses on the filtered level.
//   clk   : system clock
//   rst   : asynchronous active-low reset (filtered level resets high)
//   line  : raw bus level
//   level : filtered level
//   rise  : one-cycle pulse after level goes 0 -> 1
//   fall  : one-cycle pulse after level goes 1 -> 0
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned    CntW   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN - 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], line};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
    end
  end

  // The level flips only after FILTER_LEN consecutive samples disagree with it;
  // any agreeing sample restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~prev_q;
  assign fall  = ~level_q & prev_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target endpoint exposing a bank of 2**ADDR_W 8-bit registers.
// Protocol: address byte, then (write) pointer byte and data bytes, or
// (read) data bytes starting at the persistent pointer.
//   clk, rst     : system clock, asynchronous active-low reset
//   scl_i, sda_i : bus line levels (SCL is input only, no stretching)
//   sda_o, sda_t : open-drain SDA driver (sda_o fixed 0, sda_t=1 releases)
//   reg_wr_*     : one-cycle register write strobe with address and data
//   reg_rd_addr  : current pointer; reg_rd_data returns that register
//   busy         : address-matched transaction in progress
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  ADDRESS    = 7'h41,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_o,
  output logic              sda_t,
  output logic              reg_wr_en,
  output logic [ADDR_W-1:0] reg_wr_addr,
  output logic [7:0]        reg_wr_data,
  output logic [ADDR_W-1:0] reg_rd_addr,
  input  logic [7:0]        reg_rd_data,
  output logic              busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_scl_filter (
    .clk   (clk),
    .rst   (rst),
    .line  (scl_i),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sda_filter (
    .clk   (clk),
    .rst   (rst),
    .line  (sda_i),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  i2c_state_e         state_q, state_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         shift_in;
  logic               rw_q, rw_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic               sda_t_q, sda_t_d;
  logic               busy_q, busy_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               rd_load_q, rd_load_d;

  assign shift_in = {shift_q[6:0], sda_lvl};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rw_q      <= 1'b0;
      ptr_q     <= '0;
      sda_t_q   <= 1'b1;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rw_q      <= rw_d;
      ptr_q     <= ptr_d;
      sda_t_q   <= sda_t_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_load_q <= rd_load_d;
    end
  end

  // Next-state logic. Bits are shifted on SCL rise; SDA drive changes on SCL fall.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rw_d      = rw_q;
    ptr_d     = ptr_q;
    sda_t_d   = sda_t_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_load_d = rd_load_q;

    if (stop_det) begin
      state_d   = StIdle;
      sda_t_d   = 1'b1;
      busy_d    = 1'b0;
      rd_load_d = 1'b0;
    end else if (start_det) begin
      // busy is left alone so a repeated START keeps an owned transaction busy
      state_d   = StAddr;
      bit_cnt_d = '0;
      sda_t_d   = 1'b1;
      rd_load_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StIgnore: begin
          sda_t_d = 1'b1;
        end

        StAddr: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (scl_fall && bit_cnt_q == BitsPerByte) begin
            if (shift_q[7:1] == ADDRESS) begin
              state_d = StAckAddr;
              sda_t_d = AckLevel;
              busy_d  = 1'b1;
              rw_d    = shift_q[RwBit];
            end else begin
              state_d = StIgnore;
              busy_d  = 1'b0;
            end
          end
        end

        StAckAddr: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (rw_q) begin
              // MSB goes out on the same edge that ends the ACK
              state_d = StRdData;
              shift_d = {reg_rd_data[6:0], 1'b1};
              sda_t_d = reg_rd_data[7];
            end else begin
              state_d = StWrPtr;
              sda_t_d = 1'b1;
            end
          end
        end

        StWrPtr: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (scl_fall && bit_cnt_q == BitsPerByte) begin
            ptr_d   = shift_q[ADDR_W-1:0];
            sda_t_d = AckLevel;
            state_d = StAckPtr;
          end
        end

        StWrData: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LastBit) begin
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = shift_in;
              ptr_d     = ptr_q + 1'b1;
            end
          end else if (scl_fall && bit_cnt_q == BitsPerByte) begin
            sda_t_d = AckLevel;
            state_d = StAckData;
          end
        end

        StAckPtr, StAckData: begin
          if (scl_fall) begin
            sda_t_d   = 1'b1;
            bit_cnt_d = '0;
            state_d   = StWrData;
          end
        end

        StRdData: begin
          if (scl_rise) begin
            // We released the line but someone holds it low: back off
            if (sda_t_q && !sda_lvl) begin
              state_d = StIgnore;
              sda_t_d = 1'b1;
              busy_d  = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else if (scl_fall) begin
            if (rd_load_q) begin
              shift_d   = {reg_rd_data[6:0], 1'b1};
              sda_t_d   = reg_rd_data[7];
              rd_load_d = 1'b0;
            end else if (bit_cnt_q == BitsPerByte) begin
              sda_t_d = 1'b1;
              state_d = StRdAck;
            end else begin
              sda_t_d = shift_q[7];
              shift_d = {shift_q[6:0], 1'b1};
            end
          end
        end

        StRdAck: begin
          if (scl_rise) begin
            if (sda_lvl == NackLevel) begin
              state_d = StIgnore;
              busy_d  = 1'b0;
            end else begin
              // Next byte is fetched at the following fall, once reg_rd_data
              // has had time to follow the new pointer.
              ptr_d     = ptr_q + 1'b1;
              bit_cnt_d = '0;
              rd_load_d = 1'b1;
              state_d   = StRdData;
            end
          end
        end

        default: begin
          state_d = StIdle;
          sda_t_d = 1'b1;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    sda_o       = 1'b0;
    sda_t       = sda_t_q;
    busy        = busy_q;
    reg_wr_en   = wr_en_q;
    reg_wr_addr = wr_addr_q;
    reg_wr_data = wr_data_q;
    reg_rd_addr = ptr_q;
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Self-checking bench for i2c_target_regs: a bit-banged bus controller,
// table-driven write transactions, hand sequences for read, glitch and reset.
module tb_i2c_target_regs;

  localparam int unsigned AW   = 4;
  localparam int unsigned FL   = 3;
  localparam int unsigned HALF = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          scl_m, sda_m;
  logic          sda_line;
  logic          sda_o, sda_t;
  logic          reg_wr_en;
  logic [AW-1:0] reg_wr_addr, reg_rd_addr;
  logic [7:0]    reg_wr_data, reg_rd_data;
  logic          busy;
  logic [7:0]    mem [16];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Open-drain wired-AND of controller and target
  assign sda_line    = sda_m & (sda_t | sda_o);
  assign reg_rd_data = mem[reg_rd_addr];

  i2c_target_regs #(
    .ADDRESS    (7'h41),
    .ADDR_W     (AW),
    .FILTER_LEN (FL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scl_i       (scl_m),
    .sda_i       (sda_line),
    .sda_o       (sda_o),
    .sda_t       (sda_t),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .reg_rd_addr (reg_rd_addr),
    .reg_rd_data (reg_rd_data),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write scoreboard
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;
  wr_t exp_q[$];

  always @(negedge clk) begin
    if (rst && reg_wr_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write",
                 reg_wr_addr, reg_wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(reg_wr_addr), 32'(e.addr));
        check("wr_data", 32'(reg_wr_data), 32'(e.data));
      end
    end
  end

  // Counts any SDA drive while watching a transaction addressed elsewhere
  logic watch_nd = 1'b0;
  int   nd_hits  = 0;
  always @(negedge clk) begin
    if (watch_nd && rst && !sda_t) nd_hits++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Works from idle bus or from SCL low (repeated START)
  task automatic i2c_start();
    wait_clk(10); sda_m = 1'b1;
    wait_clk(10); scl_m = 1'b1;
    wait_clk(HALF); sda_m = 1'b0;
    wait_clk(HALF); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(10); sda_m = 1'b0;
    wait_clk(10); scl_m = 1'b1;
    wait_clk(HALF); sda_m = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic i2c_bit(input logic b, output logic s);
    wait_clk(10); sda_m = b;
    wait_clk(10); scl_m = 1'b1;
    wait_clk(10); s = sda_line;
    wait_clk(10); scl_m = 1'b0;
  endtask

  // Same bit with an SDA pulse of FL-1 clocks inside the SCL-high window
  task automatic i2c_bit_glitch(input logic b, output logic s);
    wait_clk(10); sda_m = b;
    wait_clk(10); scl_m = 1'b1;
    wait_clk(5);  s = sda_line;
    wait_clk(3);  sda_m = ~b;
    wait_clk(FL - 1); sda_m = b;
    wait_clk(10); scl_m = 1'b0;
  endtask

  task automatic i2c_write(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
    i2c_bit(1'b1, ack);
  endtask

  task automatic i2c_read(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, s);
      d[i] = s;
    end
    i2c_bit(mack, s);
  endtask

  typedef struct {
    logic [6:0]    dev;
    logic [7:0]    ptr;
    logic [7:0]    d0;
    logic [7:0]    d1;
    logic          exp_ack;   // expected level on every ACK slot
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] d;
    logic [7:0] ab;

    vecs[0] = '{7'h41, 8'h03, 8'hA5, 8'h5A, 1'b0, 4'h3, 4'h4};
    vecs[1] = '{7'h42, 8'hFF, 8'h00, 8'hFF, 1'b1, 4'h0, 4'h0};
    vecs[2] = '{7'h41, 8'h0F, 8'hC3, 8'h3C, 1'b0, 4'hF, 4'h0};
    vecs[3] = '{7'h41, 8'h27, 8'h01, 8'h02, 1'b0, 4'h7, 4'h8};
    vecs[4] = '{7'h40, 8'h00, 8'hFF, 8'h81, 1'b1, 4'h0, 4'h0};

    for (int i = 0; i < 16; i++) mem[i] = 8'h80 + 8'(i);
    mem[2] = 8'h11;
    mem[3] = 8'h22;

    // Reset state
    rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    wait_clk(3);
    check("rst_sda_t",   32'(sda_t), 32'd1);
    check("rst_sda_o",   32'(sda_o), 32'd0);
    check("rst_wr_en",   32'(reg_wr_en), 32'd0);
    check("rst_wr_addr", 32'(reg_wr_addr), 32'd0);
    check("rst_wr_data", 32'(reg_wr_data), 32'd0);
    check("rst_ptr",     32'(reg_rd_addr), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    rst = 1'b1;
    wait_clk(5);

    // Table-driven write transactions
    for (int v = 0; v < 5; v++) begin
      nd_hits  = 0;
      watch_nd = vecs[v].exp_ack;
      i2c_start();
      i2c_write({vecs[v].dev, 1'b0}, ack);
      check("addr_ack", 32'(ack), 32'(vecs[v].exp_ack));
      i2c_write(vecs[v].ptr, ack);
      check("ptr_ack", 32'(ack), 32'(vecs[v].exp_ack));
      check("busy_mid", 32'(busy), 32'(!vecs[v].exp_ack));
      if (!vecs[v].exp_ack) exp_q.push_back('{vecs[v].a0, vecs[v].d0});
      i2c_write(vecs[v].d0, ack);
      check("d0_ack", 32'(ack), 32'(vecs[v].exp_ack));
      if (!vecs[v].exp_ack) exp_q.push_back('{vecs[v].a1, vecs[v].d1});
      i2c_write(vecs[v].d1, ack);
      check("d1_ack", 32'(ack), 32'(vecs[v].exp_ack));
      i2c_stop();
      wait_clk(10);
      check("busy_after_stop", 32'(busy), 32'd0);
      check("wr_drain", 32'(exp_q.size()), 32'd0);
      if (vecs[v].exp_ack) check("no_drive", 32'(nd_hits), 32'd0);
      watch_nd = 1'b0;
    end

    // Pointer write, repeated START, two-byte read
    i2c_start();
    i2c_write(8'h82, ack);
    check("rd_addr_w_ack", 32'(ack), 32'd0);
    i2c_write(8'h02, ack);
    check("rd_ptr_ack", 32'(ack), 32'd0);
    i2c_start();
    i2c_write(8'h83, ack);
    check("rd_addr_r_ack", 32'(ack), 32'd0);
    i2c_read(1'b0, d);
    check("rd_byte0", 32'(d), 32'h11);
    i2c_read(1'b1, d);
    check("rd_byte1", 32'(d), 32'h22);
    wait_clk(15);
    check("rd_nack_release", 32'(sda_t), 32'd1);
    check("rd_nack_busy", 32'(busy), 32'd0);
    check("rd_ptr_after", 32'(reg_rd_addr), 32'd3);
    i2c_stop();

    // Read with no pointer phase continues from the stored pointer
    i2c_start();
    i2c_write(8'h83, ack);
    check("persist_ack", 32'(ack), 32'd0);
    i2c_read(1'b1, d);
    check("persist_byte", 32'(d), 32'h22);
    i2c_stop();

    // Short SDA glitches during the address byte must not frame START/STOP
    i2c_start();
    ab = 8'h82;
    for (int i = 7; i >= 0; i--) begin
      if (i >= 6) i2c_bit_glitch(ab[i], s);
      else        i2c_bit(ab[i], s);
    end
    i2c_bit(1'b1, ack);
    check("glitch_addr_ack", 32'(ack), 32'd0);
    i2c_write(8'h05, ack);
    check("glitch_ptr_ack", 32'(ack), 32'd0);
    exp_q.push_back('{4'h5, 8'h77});
    i2c_write(8'h77, ack);
    check("glitch_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    wait_clk(10);
    check("glitch_wr_drain", 32'(exp_q.size()), 32'd0);

    // Reset while the target drives the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) i2c_bit(ab[i], s);
    sda_m = 1'b1;
    wait_clk(12);
    check("ack_driven", 32'(sda_t), 32'd0);
    #3 rst = 1'b0;
    #1;
    check("rst_async_sda_t", 32'(sda_t), 32'd1);
    check("rst_async_busy", 32'(busy), 32'd0);
    wait_clk(5);
    rst = 1'b1;
    i2c_stop();
    i2c_start();
    i2c_write(8'h82, ack);
    check("post_rst_addr_ack", 32'(ack), 32'd0);
    i2c_write(8'h09, ack);
    check("post_rst_ptr_ack", 32'(ack), 32'd0);
    exp_q.push_back('{4'h9, 8'hE1});
    i2c_write(8'hE1, ack);
    check("post_rst_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    wait_clk(10);
    check("post_rst_wr_drain", 32'(exp_q.size()), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600_000;
    n_bad++;
    $display("FAIL timeout: got no end of test, expected completion before 600us");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
